// File: rtl/dmul_pkg.sv
// Shared types for the rotation stochastic multiplier: FSM state encoding
// and the width of the ones counter.
package dmul_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // A full run is 2^(2*WIDTH) bits, so its ones count needs 2*WIDTH+1 bits.
  function automatic int cnt_w(input int width);
    return 2 * width + 1;
  endfunction

endpackage

// File: rtl/dmul_rot_param_sng_cmp.sv
// Stochastic number generator comparator: emits 1 while the operand exceeds
// the running counter, producing a unary stream of density val/2^WIDTH.
module sng_cmp #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic [WIDTH-1:0] cnt_i,
  output logic             bit_o
);

  assign bit_o = (val_i > cnt_i);

endmodule

// File: rtl/dmul_rot_param.sv
// Deterministic rotation-based stochastic multiplier (AND / XNOR product stream).
// Define DMUL_ACC_EN to build the oCnt ones accumulator; otherwise oCnt is tied to 0.
module dmul_rot_param
  import dmul_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter bit BIPOLAR = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           iA,
  input  logic [WIDTH-1:0]           iB,
  input  logic                       loadA,
  input  logic                       loadB,
  output logic                       oC,
  output logic                       oValid,
  output logic                       oDone,
  output logic                       oBusy,
  output logic [cnt_w(WIDTH)-1:0]    oCnt
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, cnt_a_q, cnt_b_q;
  logic             got_a_q, got_b_q;
  logic             c_q, vld_q, done_q;
  logic             a_bit, b_bit, c_d;
  logic             entry, restart, last;

  sng_cmp #(.WIDTH(WIDTH)) u_cmp_a (.val_i(a_q), .cnt_i(cnt_a_q), .bit_o(a_bit));
  sng_cmp #(.WIDTH(WIDTH)) u_cmp_b (.val_i(b_q), .cnt_i(cnt_b_q), .bit_o(b_bit));

  assign c_d     = BIPOLAR ? ~(a_bit ^ b_bit) : (a_bit & b_bit);
  assign entry   = (state_q == IDLE) && got_a_q && got_b_q;
  assign restart = (state_q == RUN) && (loadA || loadB);
  assign last    = (cnt_a_q == CNT_MAX) && (cnt_b_q == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      got_a_q <= 1'b0;
      got_b_q <= 1'b0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      c_q     <= 1'b0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      c_q    <= 1'b0;
      vld_q  <= 1'b0;
      done_q <= 1'b0;
      if (loadA) a_q <= iA;
      if (loadB) b_q <= iB;
      case (state_q)
        IDLE: begin
          if (loadA) got_a_q <= 1'b1;
          if (loadB) got_b_q <= 1'b1;
          if (got_a_q && got_b_q) begin
            state_q <= RUN;
            got_a_q <= 1'b0;
            got_b_q <= 1'b0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
          end
        end
        RUN: begin
          vld_q <= 1'b1;
          // A reload emits one filler 0 bit while the counters rewind.
          if (loadA || loadB) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
          end else begin
            c_q     <= c_d;
            cnt_a_q <= cnt_a_q + 1'b1;
            if (cnt_a_q == CNT_MAX) cnt_b_q <= cnt_b_q + 1'b1;
            if (last) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oC     = c_q;
  assign oValid = vld_q;
  assign oDone  = done_q;
  assign oBusy  = (state_q == RUN);

`ifdef DMUL_ACC_EN
  logic [cnt_w(WIDTH)-1:0] acc_q;

  // Counts with the bit being registered so oCnt is final alongside oDone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (entry || restart) begin
      acc_q <= '0;
    end else if ((state_q == RUN) && c_d) begin
      acc_q <= acc_q + 1'b1;
    end
  end

  assign oCnt = acc_q;
`else
  assign oCnt = '0;
`endif

endmodule

// File: doc/dmul_rot_param.md
DMUL_ROT_PARAM -- requirements
Module: dmul_rot_param

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal range 2..12.
REQ-002 Parameter BIPOLAR, default 0: 0 = unipolar (AND), 1 = bipolar (XNOR).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 iA  input  WIDTH  operand A, binary fraction iA/2^WIDTH.
REQ-006 iB  input  WIDTH  operand B, binary fraction iB/2^WIDTH.
REQ-007 loadA  input  1  latch iA into operand register A_r this cycle.
REQ-008 loadB  input  1  latch iB into operand register B_r this cycle.
REQ-009 oC  output  1  registered product bitstream.
REQ-010 oValid  output  1  high while oC carries a bit of the current run.
REQ-011 oDone  output  1  one-cycle pulse on the last bit of a run.
REQ-012 oBusy  output  1  high in RUN state.
REQ-013 oCnt  output  2*WIDTH+1  count of ones in oC for the current/last run.

Function
REQ-014 FSM states IDLE, RUN; reset state IDLE.
REQ-015 Flags gotA/gotB set on loadA/loadB; IDLE->RUN in the cycle after both flags are set; both flags clear on entry to RUN.
REQ-016 Counters cntA, cntB (WIDTH bits each) are zero on RUN entry; cntA increments every RUN cycle; cntB increments only when cntA == 2^WIDTH-1 (rotation), so each A period pairs with one B value.
REQ-017 Each RUN cycle: a = (A_r > cntA), b = (B_r > cntB); oC <= a&b (BIPOLAR=0) or ~(a^b) (BIPOLAR=1); oValid <= 1.
REQ-018 Latency: first oValid one cycle after RUN entry; run length exactly 2^(2*WIDTH) valid bits, contiguous.
REQ-019 When cntA and cntB are both all-ones, the FSM returns to IDLE; oDone is high in the same cycle as the final oValid bit.
REQ-020 Unipolar result exact: ones in a run = A_r*B_r.
REQ-021 Bipolar result exact: ones = A_r*B_r + (2^WIDTH-A_r)*(2^WIDTH-B_r).
REQ-022 loadA or loadB during RUN: new operand latched; counters, oCnt and run restart from zero next cycle; no oDone for the aborted run; oValid stays high.
REQ-023 loadA and loadB in the same IDLE cycle: both latch; RUN entered next cycle.
REQ-024 Outside RUN: oC=0, oValid=0, oDone=0; A_r/B_r hold last value.
REQ-025 iA=0 (unipolar): all-zero stream of full length, oDone still pulses.

Reset
REQ-026 rst_n low asynchronously forces: state IDLE, A_r=B_r=0, flags 0, cntA=cntB=0, oC=0, oValid=0, oDone=0, oBusy=0, oCnt=0.
REQ-027 Reset mid-run aborts without oDone; after release a fresh loadA+loadB is required.

Configuration
REQ-028 Macro DMUL_ACC_EN defined: oCnt increments on each valid 1 bit of oC, clears on RUN entry/restart, holds after oDone until the next RUN entry.
REQ-029 DMUL_ACC_EN undefined: no accumulator logic; oCnt tied to 0; port list unchanged.

Structure
REQ-030 Package dmul_pkg holds the FSM state enum (IDLE, RUN) and a constant function for count width (2*WIDTH+1).
REQ-031 Sub-module sng_cmp (WIDTH-bit operand vs. counter comparator, output 1 bit) instantiated twice, for A and B.

Verification
REQ-032 WIDTH=4, unipolar, iA=8, iB=8, loadA=loadB=1 one cycle -> 256 valid bits, oCnt=64, single oDone on bit 256.
REQ-033 WIDTH=4, unipolar, iA=15, iB=15 -> oCnt=225; iA=0, iB=9 -> oCnt=0, oDone still pulses after 256 bits.
REQ-034 WIDTH=4, BIPOLAR=1, iA=8, iB=8 -> oCnt=128; iA=12, iB=4 -> oCnt=48+48=96.
REQ-035 WIDTH=4, loadA in cycle 1, loadB in cycle 5 -> RUN starts cycle 6; new loadA at bit 100 -> restart, oCnt cleared, next oDone 256 bits after restart.
REQ-036 WIDTH=8, iA=128, iB=128, rst_n low at bit 1000 -> all outputs 0 immediately, no oDone; reload -> full 65536-bit run, oCnt=16384.
